// File: rtl/ps2_keymap_ctrl.sv
// ps2_keymap_ctrl: PS/2 scan-code sequencer keeping P1/P2 held-key bitmaps with watchdog and flush.
module ps2_keymap_ctrl #(
  parameter int SEQ_TIMEOUT = 62500,
  parameter int PAUSE_LEN   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic [4:0] p1keys,
  output logic [4:0] p2keys,
  output logic       key_event,
  output logic       seq_error,
  output logic [7:0] debug_leds
);
  localparam int TW = $clog2(SEQ_TIMEOUT);
  localparam int SW = $clog2(PAUSE_LEN + 1);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [SW-1:0] r_skip, w_skip_nxt;
  logic [4:0] r_p1, r_p2, w_p1_nxt, w_p2_nxt, w_m1, w_m2;
  logic r_evt, r_err, w_err_nxt, w_ext, w_brk, w_flush;
  logic [7:0] r_leds;
  assign w_ext = (r_state == EXT) || (r_state == EXT_BRK);
  assign w_brk = (r_state == BRK) || (r_state == EXT_BRK);
  assign w_flush = (byte_data == 8'hAA) || (byte_data == 8'hFC) || (byte_data == 8'h00) || (byte_data == 8'hFF);
  // P1 keys ignore the E0 prefix as a mapping; P2 keys accept both forms
  assign w_m1 = w_ext ? 5'b0 : {byte_data == 8'h29, byte_data == 8'h23, byte_data == 8'h1C,
                                byte_data == 8'h1B, byte_data == 8'h1D};
  assign w_m2 = {byte_data == 8'h5A, byte_data == 8'h74, byte_data == 8'h6B,
                 byte_data == 8'h72, byte_data == 8'h75};
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    w_skip_nxt  = r_skip;
    w_p1_nxt    = r_p1;
    w_p2_nxt    = r_p2;
    w_err_nxt   = 1'b0;
    if (byte_valid) begin
      if (w_flush) begin
        w_state_nxt = IDLE;
        w_skip_nxt  = '0;
        w_p1_nxt    = '0;
        w_p2_nxt    = '0;
        w_err_nxt   = byte_data != 8'hAA;
      end else if (r_state == SKIP) begin
        w_skip_nxt  = r_skip - 1'b1;
        w_state_nxt = (r_skip <= 1) ? IDLE : SKIP;
      end else if (r_state == IDLE && byte_data == 8'hE0) begin
        w_state_nxt = EXT;
      end else if (r_state == IDLE && byte_data == 8'hF0) begin
        w_state_nxt = BRK;
      end else if (r_state == IDLE && byte_data == 8'hE1) begin
        w_state_nxt = SKIP;
        w_skip_nxt  = SW'(PAUSE_LEN);
      end else if (r_state == EXT && byte_data == 8'hF0) begin
        w_state_nxt = EXT_BRK;
      end else begin
        w_state_nxt = IDLE;
        w_p1_nxt    = w_brk ? (r_p1 & ~w_m1) : (r_p1 | w_m1);
        w_p2_nxt    = w_brk ? (r_p2 & ~w_m2) : (r_p2 | w_m2);
      end
    end else if (r_state != IDLE) begin
      if (r_timer == TW'(SEQ_TIMEOUT - 1)) begin
        w_state_nxt = IDLE;
        w_skip_nxt  = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_timer_nxt = r_timer + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_skip  <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_evt   <= 1'b0;
      r_err   <= 1'b0;
      r_leds  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_skip  <= w_skip_nxt;
      r_p1    <= w_p1_nxt;
      r_p2    <= w_p2_nxt;
      r_evt   <= (w_p1_nxt != r_p1) || (w_p2_nxt != r_p2);
      r_err   <= w_err_nxt;
      if (byte_valid) r_leds <= byte_data;
    end
  end
  assign p1keys     = r_p1;
  assign p2keys     = r_p2;
  assign key_event  = r_evt;
  assign seq_error  = r_err;
  assign debug_leds = r_leds;
endmodule

// File: tb/tb_ps2_keymap_ctrl.sv
// tb_ps2_keymap_ctrl: sequence-queue reference model compared every cycle, plus directed literal checks.
module tb_ps2_keymap_ctrl;
  localparam int T  = 50;
  localparam int PL = 7;
  logic clk = 0, rst_n = 0, byte_valid = 0;
  logic [7:0] byte_data = 0;
  logic [4:0] p1keys, p2keys;
  logic key_event, seq_error;
  logic [7:0] debug_leds;
  int vectors = 0, fails = 0;

  ps2_keymap_ctrl #(.SEQ_TIMEOUT(T), .PAUSE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .p1keys(p1keys), .p2keys(p2keys), .key_event(key_event), .seq_error(seq_error),
    .debug_leds(debug_leds)
  );

  always #5 clk = ~clk;

  // reference model: collects a sequence as a byte queue and interprets it when complete
  logic [7:0] p1c[5] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
  logic [7:0] p2c[5] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
  logic [4:0] m_p1 = 0, m_p2 = 0;
  logic m_evt = 0, m_err = 0;
  logic [7:0] m_leds = 0;
  logic [7:0] q[$];
  int m_skip = 0, m_idle = 0;

  task automatic model_byte(input logic [7:0] b);
    logic [4:0] o1, o2;
    logic ext, brk;
    o1 = m_p1; o2 = m_p2;
    m_leds = b;
    if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) begin
      q.delete(); m_skip = 0; m_p1 = 0; m_p2 = 0; m_err = (b != 8'hAA);
    end else if (m_skip > 0) begin
      m_skip--;
    end else begin
      q.push_back(b);
      if (q.size() == 1 && b == 8'hE1) begin
        m_skip = PL; q.delete();
      end else if (q.size() == 1 && (b == 8'hE0 || b == 8'hF0)) begin
      end else if (q.size() == 2 && q[0] == 8'hE0 && b == 8'hF0) begin
      end else begin
        ext = q[0] == 8'hE0;
        brk = q.size() >= 2 && q[q.size()-2] == 8'hF0;
        for (int i = 0; i < 5; i++) begin
          if (!ext && b == p1c[i]) m_p1[i] = !brk;
          if (b == p2c[i]) m_p2[i] = !brk;
        end
        q.delete();
      end
    end
    m_evt = (o1 != m_p1) || (o2 != m_p2);
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_p1 = 0; m_p2 = 0; m_evt = 0; m_err = 0; m_leds = 0;
      q.delete(); m_skip = 0; m_idle = 0;
    end else begin
      m_evt = 0; m_err = 0;
      if (byte_valid) begin
        m_idle = 0;
        model_byte(byte_data);
      end else if (q.size() > 0 || m_skip > 0) begin
        if (m_idle == T - 1) begin
          q.delete(); m_skip = 0; m_idle = 0; m_err = 1;
        end else m_idle++;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("p1keys", {3'b0, p1keys}, {3'b0, m_p1});
    chk("p2keys", {3'b0, p2keys}, {3'b0, m_p2});
    chk("key_event", {7'b0, key_event}, {7'b0, m_evt});
    chk("seq_error", {7'b0, seq_error}, {7'b0, m_err});
    chk("debug_leds", debug_leds, m_leds);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk); byte_valid = 1; byte_data = b;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); byte_valid = 0; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pool[10];
    logic [7:0] fl[4];
    logic [7:0] b;
    int r, g;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
    fl = '{8'hAA, 8'hFC, 8'h00, 8'hFF};
    idle(3);
    chk("rst_p1", {3'b0, p1keys}, 8'h00);
    chk("rst_leds", debug_leds, 8'h00);
    @(negedge clk); rst_n = 1;
    send(8'h1D); idle(1);
    chk("make_w", {3'b0, p1keys}, 8'h01);
    chk("make_w_evt", {7'b0, key_event}, 8'h01);
    send(8'hF0); send(8'h1D); idle(1);
    chk("break_w", {3'b0, p1keys}, 8'h00);
    chk("break_w_evt", {7'b0, key_event}, 8'h01);
    send(8'hE0); send(8'h75); idle(1);
    chk("ext_make_up", {3'b0, p2keys}, 8'h01);
    send(8'hE0); send(8'hF0); send(8'h75); idle(1);
    chk("ext_break_up", {3'b0, p2keys}, 8'h00);
    send(8'h75); idle(1);
    chk("plain_up", {3'b0, p2keys}, 8'h01);
    send(8'hE0); send(8'h1D); idle(1);
    chk("e0_p1_unmapped", {3'b0, p1keys}, 8'h00);
    send(8'h1D); idle(1);
    chk("idle_after_e0", {3'b0, p1keys}, 8'h01);
    send(8'hF0); send(8'h1D); idle(2);
    send(8'h1D); send(8'h23); idle(1);
    chk("hold_wd", {3'b0, p1keys}, 8'h09);
    send(8'h1D); idle(1);
    chk("typematic_no_evt", {7'b0, key_event}, 8'h00);
    send(8'hFC); idle(1);
    chk("fc_p1", {3'b0, p1keys}, 8'h00);
    chk("fc_p2", {3'b0, p2keys}, 8'h00);
    chk("fc_err", {7'b0, seq_error}, 8'h01);
    chk("fc_evt", {7'b0, key_event}, 8'h01);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(1);
    chk("pause_nochange", {3'b0, p1keys}, 8'h00);
    send(8'h29); idle(1);
    chk("after_pause", {3'b0, p1keys}, 8'h10);
    send(8'hAA); idle(1);
    chk("bat_no_err", {7'b0, seq_error}, 8'h00);
    send(8'hF0); idle(T);
    chk("wd_not_yet", {7'b0, seq_error}, 8'h00);
    idle(1);
    chk("wd_fire", {7'b0, seq_error}, 8'h01);
    send(8'h1B); idle(1);
    chk("make_after_wd", {3'b0, p1keys}, 8'h02);
    send(8'h75); send(8'h72); send(8'h6B); send(8'h74); send(8'h5A); idle(1);
    chk("p2_all", {3'b0, p2keys}, 8'h1F);
    send(8'hE0); send(8'hF0); idle(1);
    #2 rst_n = 0;
    #1 chk("async_rst_p2", {3'b0, p2keys}, 8'h00);
    chk("async_rst_p1", {3'b0, p1keys}, 8'h00);
    chk("async_rst_leds", debug_leds, 8'h00);
    idle(2);
    @(negedge clk); rst_n = 1;
    send(8'h72); idle(1);
    chk("after_rst_down", {3'b0, p2keys}, 8'h02);
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(99);
      if (r < 45) b = pool[$urandom_range(9)];
      else if (r < 55) b = 8'hE0;
      else if (r < 70) b = 8'hF0;
      else if (r < 73) b = 8'hE1;
      else if (r < 75) b = fl[$urandom_range(3)];
      else b = 8'($urandom_range(255));
      send(b);
      g = $urandom_range(99);
      if (g >= 95) idle($urandom_range(T + 3, T - 3));
      else if (g >= 50) idle($urandom_range(4, 1));
    end
    idle(T + 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
